// File: rtl/lda_cmd_master.sv
// Avalon-MM master that programs the line-drawing accelerator registers for one
// line command at a time, then waits for completion by stall or status polling.
module lda_cmd_master #(
    parameter int POLL_GAP = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [8:0]       cmd_x0,
    input  logic [8:0]       cmd_x1,
    input  logic [7:0]       cmd_y0,
    input  logic [7:0]       cmd_y1,
    input  logic [2:0]       cmd_color,
    output logic [2:0]       m_address,
    output logic             m_read,
    output logic             m_write,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             m_waitrequest,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_lines_done
);

    typedef enum logic [2:0] {
        IDLE, WR_MODE, WR_START, WR_END, WR_COLOR, WR_GO, POLL_WAIT, POLL_RD
    } state_t;

    typedef struct packed {
        logic       mode;
        logic [8:0] x0;
        logic [7:0] y0;
        logic [8:0] x1;
        logic [7:0] y1;
        logic [2:0] color;
    } cmd_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } req_t;

    localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
    // With no gap configured the status read follows the go/busy read directly.
    localparam state_t      POLL_NEXT = (POLL_GAP == 0) ? POLL_RD : POLL_WAIT;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    req_t              req_q, req_d;
    logic [15:0]       gap_q, gap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_mode_q, last_mode_d;
    logic [2:0]        last_color_q, last_color_d;
    logic              cvalid_q, cvalid_d;
    logic              xfer;
    logic              unused_rd;

    assign xfer      = (req_q.rd | req_q.wr) & ~m_waitrequest;
    assign unused_rd = &{1'b0, m_readdata[31:1]};

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        gap_d        = gap_q;
        cnt_d        = cnt_q;
        last_mode_d  = last_mode_q;
        last_color_d = last_color_q;
        cvalid_d     = cvalid_q;
        req_d        = '0;

        case (state_q)
            IDLE: if (cmd_valid) begin
                cmd_d   = '{cmd_mode, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
                state_d = (cvalid_q && cmd_mode == last_mode_q) ? WR_START : WR_MODE;
            end
            WR_MODE: if (xfer) begin
                last_mode_d = cmd_q.mode;
                state_d     = WR_START;
            end
            WR_START: if (xfer) state_d = WR_END;
            WR_END: if (xfer)
                state_d = (cvalid_q && cmd_q.color == last_color_q) ? WR_GO : WR_COLOR;
            WR_COLOR: if (xfer) begin
                last_color_d = cmd_q.color;
                cvalid_d     = 1'b1;
                state_d      = WR_GO;
            end
            WR_GO: if (xfer) begin
                if (cmd_q.mode) begin
                    state_d = POLL_NEXT;
                    gap_d   = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            POLL_WAIT: begin
                if (gap_q == GAP_LAST) state_d = POLL_RD;
                else                   gap_d   = gap_q + 16'd1;
            end
            POLL_RD: if (xfer) begin
                if (m_readdata[0]) begin
                    state_d = POLL_NEXT;
                    gap_d   = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests are decoded from the next state so they leave a register.
        case (state_d)
            WR_MODE:  req_d = '{1'b0, 1'b1, 3'd0, {31'd0, cmd_d.mode}};
            WR_START: req_d = '{1'b0, 1'b1, 3'd3, {15'd0, cmd_d.y0, cmd_d.x0}};
            WR_END:   req_d = '{1'b0, 1'b1, 3'd4, {15'd0, cmd_d.y1, cmd_d.x1}};
            WR_COLOR: req_d = '{1'b0, 1'b1, 3'd5, {29'd0, cmd_d.color}};
            WR_GO:    req_d = '{1'b0, 1'b1, 3'd2, 32'd0};
            POLL_RD:  req_d = '{1'b1, 1'b0, 3'd1, 32'd0};
            default:  req_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            req_q        <= '0;
            gap_q        <= '0;
            cnt_q        <= '0;
            last_mode_q  <= 1'b0;
            last_color_q <= '0;
            cvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            req_q        <= req_d;
            gap_q        <= gap_d;
            cnt_q        <= cnt_d;
            last_mode_q  <= last_mode_d;
            last_color_q <= last_color_d;
            cvalid_q     <= cvalid_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE) && !reset;
    assign o_busy       = (state_q != IDLE);
    assign o_lines_done = cnt_q;
    assign m_read       = req_q.rd;
    assign m_write      = req_q.wr;
    assign m_address    = req_q.addr;
    assign m_writedata  = req_q.data;

endmodule
